rand_range_gen: RTL and testbench

RAND_RANGE_GEN -- requirements
Module: rand_range_gen

---
 rtl/rand_range_gen_pkg.sv | 65 ++++++
 rtl/rand_range_gen_lfsr_core.sv | 38 +++
 rtl/rand_range_gen.sv | 125 ++++++++++++
 tb/tb_rand_range_gen.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rand_range_gen_pkg.sv
// Shared definitions for the bounded random generator: LFSR tap masks,
// FSM state encoding and the rule that keeps the LFSR out of the all-zero state.
package rand_range_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SAMPLE = 2'd1,
        ST_DONE   = 2'd2
    } rrg_state_e;

    // Right-shifting Galois toggle masks of maximal-length polynomials, LSB-aligned.
    function automatic logic [31:0] lfsr_taps(input int len);
        case (len)
            4:       return 32'h0000_000C;
            5:       return 32'h0000_0014;
            6:       return 32'h0000_0030;
            7:       return 32'h0000_0060;
            8:       return 32'h0000_00B8;
            9:       return 32'h0000_0110;
            10:      return 32'h0000_0240;
            11:      return 32'h0000_0500;
            12:      return 32'h0000_0829;
            13:      return 32'h0000_100D;
            14:      return 32'h0000_2015;
            15:      return 32'h0000_6000;
            16:      return 32'h0000_D008;
            17:      return 32'h0001_2000;
            18:      return 32'h0002_0400;
            19:      return 32'h0004_0023;
            20:      return 32'h0009_0000;
            21:      return 32'h0014_0000;
            22:      return 32'h0030_0000;
            23:      return 32'h0042_0000;
            24:      return 32'h00E1_0000;
            25:      return 32'h0120_0000;
            26:      return 32'h0200_0023;
            27:      return 32'h0400_0013;
            28:      return 32'h0900_0000;
            29:      return 32'h1400_0000;
            30:      return 32'h2000_0029;
            31:      return 32'h4800_0000;
            32:      return 32'h8020_0003;
            default: return 32'h0000_000C;
        endcase
    endfunction

    function automatic logic [31:0] width_mask(input int len);
        if (len >= 32) return 32'hFFFF_FFFF;
        return (32'd1 << len) - 32'd1;
    endfunction

    // Reset/default seed restricted to the LFSR width, never zero.
    function automatic logic [31:0] default_seed(input logic [31:0] dflt, input int len);
        logic [31:0] d;
        d = dflt & width_mask(len);
        if (d == 32'd0) d = 32'd1;
        return d;
    endfunction

    // A zero seed would lock the LFSR, so it is replaced by the default seed.
    function automatic logic [31:0] seed_fix(input logic [31:0] seed, input logic [31:0] dflt);
        return (seed == 32'd0) ? dflt : seed;
    endfunction

endpackage

// File: rtl/rand_range_gen_lfsr_core.sv
// Free-running maximal-length Galois LFSR with a loadable, zero-protected seed.
module lfsr_core
    import rand_range_gen_pkg::*;
#(
    parameter int LENGTH       = 16,
    parameter int SEED_DEFAULT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [LENGTH-1:0] seed,
    output logic [LENGTH-1:0] state
);

    localparam logic [LENGTH-1:0] TAPS    = LENGTH'(lfsr_taps(LENGTH));
    localparam logic [LENGTH-1:0] RST_VAL = LENGTH'(default_seed(32'(SEED_DEFAULT), LENGTH));

    logic [LENGTH-1:0] state_d;

    always_comb begin
        if (load) begin
            state_d = LENGTH'(seed_fix(32'(seed), 32'(RST_VAL)));
        end else if (state[0]) begin
            state_d = (state >> 1) ^ TAPS;
        end else begin
            state_d = state >> 1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RST_VAL;
        end else begin
            state <= state_d;
        end
    end

endmodule

// File: rtl/rand_range_gen.sv
// Bounded random number generator: rejection-samples a masked LFSR value below
// a latched bound, with a subtract fallback after MAX_TRY rejections.
module rand_range_gen
    import rand_range_gen_pkg::*;
#(
    parameter int LENGTH       = 16,
    parameter int SEED_DEFAULT = 1,
    parameter int MAX_TRY      = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              seed_load_i,
    input  logic [LENGTH-1:0] seed_i,
    input  logic              req_i,
    input  logic [LENGTH-1:0] bound_i,
    output logic              ready_o,
    output logic              valid_o,
    output logic [LENGTH-1:0] value_o,
    input  logic              ack_i,
    output logic [LENGTH-1:0] ram_seq_o
);

    localparam int              TRY_W    = (MAX_TRY < 1) ? 1 : $clog2(MAX_TRY + 1);
    localparam logic [TRY_W-1:0] TRY_LAST = TRY_W'(MAX_TRY);

    rrg_state_e        state_q, state_d;
    logic [LENGTH-1:0] bound_q, bound_d;
    logic [LENGTH-1:0] mask_q, mask_d;
    logic [LENGTH-1:0] value_q, value_d;
    logic [TRY_W-1:0]  try_q, try_d;
    logic [LENGTH-1:0] lfsr_state;
    logic [LENGTH-1:0] sample;

    // Smallest all-ones mask covering bound-1; the decrement keeps powers of two tight.
    function automatic logic [LENGTH-1:0] range_mask(input logic [LENGTH-1:0] bound);
        logic [LENGTH-1:0] top;
        logic [LENGTH-1:0] m;
        logic              seen;
        top  = bound - LENGTH'(1);
        seen = 1'b0;
        for (int i = LENGTH - 1; i >= 0; i--) begin
            seen = seen | top[i];
            m[i] = seen;
        end
        return m;
    endfunction

    lfsr_core #(
        .LENGTH      (LENGTH),
        .SEED_DEFAULT(SEED_DEFAULT)
    ) u_lfsr (
        .clk  (clk),
        .rst_n(rst_n),
        .load (seed_load_i),
        .seed (seed_i),
        .state(lfsr_state)
    );

    assign sample = lfsr_state & mask_q;

    always_comb begin
        state_d = state_q;
        bound_d = bound_q;
        mask_d  = mask_q;
        value_d = value_q;
        try_d   = try_q;
        case (state_q)
            ST_IDLE: begin
                if (req_i) begin
                    bound_d = bound_i;
                    mask_d  = range_mask(bound_i);
                    try_d   = '0;
                    if (bound_i <= LENGTH'(1)) begin
                        value_d = '0;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_SAMPLE;
                    end
                end
            end
            ST_SAMPLE: begin
                if (sample < bound_q) begin
                    value_d = sample;
                    state_d = ST_DONE;
                end else if (try_q == TRY_LAST) begin
                    // sample < 2*bound, so one subtraction lands inside the range
                    value_d = sample - bound_q;
                    state_d = ST_DONE;
                end else begin
                    try_d = try_q + TRY_W'(1);
                end
            end
            ST_DONE: begin
                if (ack_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            bound_q <= '0;
            mask_q  <= '0;
            value_q <= '0;
            try_q   <= '0;
        end else begin
            state_q <= state_d;
            bound_q <= bound_d;
            mask_q  <= mask_d;
            value_q <= value_d;
            try_q   <= try_d;
        end
    end

    assign ready_o   = (state_q == ST_IDLE);
    assign valid_o   = (state_q == ST_DONE);
    assign value_o   = value_q;
    assign ram_seq_o = lfsr_state;

endmodule

// File: tb/tb_rand_range_gen.sv
// Scoreboard bench for rand_range_gen: three instances (LENGTH=4, LENGTH=8,
// LENGTH=8 with MAX_TRY=1) checked against a bench-side LFSR model.
module tb_rand_range_gen;

    logic       clk;
    logic       rst_n;
    logic       req_x   [3];
    logic       ack_x   [3];
    logic       sload_x [3];
    logic [7:0] bound_x [3];
    logic [7:0] seed_x  [3];
    logic       rdy_x   [3];
    logic       vld_x   [3];
    logic [7:0] val_x   [3];
    logic [7:0] seq_x   [3];
    logic [7:0] mdl     [3];

    logic       rdy_a, vld_a, rdy_b, vld_b, rdy_c, vld_c;
    logic [3:0] val_a, seq_a;
    logic [7:0] val_b, seq_b, val_c, seq_c;

    int         total;
    int         bad;
    int         exp_q[$];
    int         lat_q[$];
    logic [255:0] seen_b;
    logic [15:0]  seen_a;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    rand_range_gen #(.LENGTH(4), .SEED_DEFAULT(1), .MAX_TRY(8)) u_a (
        .clk(clk), .rst_n(rst_n), .seed_load_i(sload_x[0]), .seed_i(seed_x[0][3:0]),
        .req_i(req_x[0]), .bound_i(bound_x[0][3:0]), .ready_o(rdy_a), .valid_o(vld_a),
        .value_o(val_a), .ack_i(ack_x[0]), .ram_seq_o(seq_a));

    rand_range_gen #(.LENGTH(8), .SEED_DEFAULT(1), .MAX_TRY(8)) u_b (
        .clk(clk), .rst_n(rst_n), .seed_load_i(sload_x[1]), .seed_i(seed_x[1]),
        .req_i(req_x[1]), .bound_i(bound_x[1]), .ready_o(rdy_b), .valid_o(vld_b),
        .value_o(val_b), .ack_i(ack_x[1]), .ram_seq_o(seq_b));

    rand_range_gen #(.LENGTH(8), .SEED_DEFAULT('h5A), .MAX_TRY(1)) u_c (
        .clk(clk), .rst_n(rst_n), .seed_load_i(sload_x[2]), .seed_i(seed_x[2]),
        .req_i(req_x[2]), .bound_i(bound_x[2]), .ready_o(rdy_c), .valid_o(vld_c),
        .value_o(val_c), .ack_i(ack_x[2]), .ram_seq_o(seq_c));

    assign rdy_x[0] = rdy_a;
    assign rdy_x[1] = rdy_b;
    assign rdy_x[2] = rdy_c;
    assign vld_x[0] = vld_a;
    assign vld_x[1] = vld_b;
    assign vld_x[2] = vld_c;
    assign val_x[0] = {4'b0000, val_a};
    assign val_x[1] = val_b;
    assign val_x[2] = val_c;
    assign seq_x[0] = {4'b0000, seq_a};
    assign seq_x[1] = seq_b;
    assign seq_x[2] = seq_c;

    function automatic logic [7:0] taps_of(input int w);
        return (w == 0) ? 8'h0C : 8'hB8;
    endfunction

    function automatic logic [7:0] sd_of(input int w);
        return (w == 2) ? 8'h5A : 8'h01;
    endfunction

    function automatic int mt_of(input int w);
        return (w == 2) ? 1 : 8;
    endfunction

    function automatic logic [7:0] step(input int w, input logic [7:0] x);
        return x[0] ? ((x >> 1) ^ taps_of(w)) : (x >> 1);
    endfunction

    function automatic logic [7:0] fix(input int w, input logic [7:0] s);
        return (s == 8'h00) ? sd_of(w) : s;
    endfunction

    function automatic int mask_of(input int b);
        int m;
        m = 1;
        while (m + 1 < b) m = m * 2 + 1;
        return m;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        for (int w = 0; w < 3; w++) begin
            if (!rst_n)          mdl[w] <= sd_of(w);
            else if (sload_x[w]) mdl[w] <= fix(w, seed_x[w]);
            else                 mdl[w] <= step(w, mdl[w]);
        end
    end

    task automatic chk(input string tag, input int got, input int want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d", tag, got, want);
        end
    endtask

    task automatic run_req(input int w, input int bnd, input bit do_rs, input logic [7:0] rs);
        int         cyc, lat, expv, wait_n, msk, hold_n;
        logic [7:0] m, s, held;
        wait_n = 0;
        while (!rdy_x[w] && wait_n < 20) begin
            @(negedge clk);
            wait_n++;
        end
        if (!rdy_x[w]) begin
            chk("rdy_wait", 0, 1);
            return;
        end
        m    = step(w, mdl[w]);
        expv = 0;
        lat  = 1;
        if (bnd > 1) begin
            msk = mask_of(bnd);
            for (int k = 0; k <= mt_of(w); k++) begin
                s = m & 8'(msk);
                if (int'(s) < bnd) begin
                    expv = int'(s);
                    lat  = k + 2;
                    break;
                end
                if (k == mt_of(w)) begin
                    expv = int'(s) - bnd;
                    lat  = k + 2;
                end
                m = (k == 0 && do_rs) ? fix(w, rs) : step(w, m);
            end
        end
        exp_q.push_back(expv);
        lat_q.push_back(lat);
        req_x[w]   = 1'b1;
        bound_x[w] = 8'(bnd);
        @(negedge clk);
        cyc        = 1;
        req_x[w]   = 1'b0;
        bound_x[w] = 8'($urandom);
        chk("busy_rdy", int'(rdy_x[w]), 0);
        if (do_rs) begin
            sload_x[w] = 1'b1;
            seed_x[w]  = rs;
        end
        while (!vld_x[w] && cyc < 16) begin
            @(negedge clk);
            cyc++;
            sload_x[w] = 1'b0;
            req_x[w]   = 1'($urandom);
        end
        sload_x[w] = 1'b0;
        if (!vld_x[w]) begin
            chk("vld_wait", 0, 1);
            void'(exp_q.pop_front());
            void'(lat_q.pop_front());
            req_x[w] = 1'b0;
            return;
        end
        chk("value", int'(val_x[w]), exp_q.pop_front());
        chk("latency", cyc, lat_q.pop_front());
        chk("in_range", (bnd <= 1) ? int'(val_x[w] == 8'h00) : int'(int'(val_x[w]) < bnd), 1);
        chk("seq", int'(seq_x[w]), int'(mdl[w]));
        if (w == 1) seen_b[val_x[w]] = 1'b1;
        held   = val_x[w];
        hold_n = $urandom_range(0, 3);
        for (int i = 0; i < hold_n; i++) begin
            @(negedge clk);
            req_x[w] = 1'($urandom);
            chk("hold_vld", int'(vld_x[w]), 1);
            chk("hold_rdy", int'(rdy_x[w]), 0);
            chk("hold_val", int'(val_x[w]), int'(held));
        end
        ack_x[w] = 1'b1;
        req_x[w] = 1'b0;
        @(negedge clk);
        ack_x[w] = 1'b0;
        chk("post_ack", int'({rdy_x[w], vld_x[w]}), 2);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic flag;
        total  = 0;
        bad    = 0;
        seen_b = '0;
        seen_a = '0;
        rst_n  = 1'b0;
        for (int w = 0; w < 3; w++) begin
            req_x[w]   = 1'b0;
            ack_x[w]   = 1'b0;
            sload_x[w] = 1'b0;
            bound_x[w] = 8'h00;
            seed_x[w]  = 8'h00;
        end
        repeat (2) @(negedge clk);
        for (int w = 0; w < 3; w++) begin
            chk("rst_rdy", int'(rdy_x[w]), 1);
            chk("rst_vld", int'(vld_x[w]), 0);
            chk("rst_val", int'(val_x[w]), 0);
            chk("rst_seq", int'(seq_x[w]), int'(sd_of(w)));
        end

        // LENGTH=4 sequence: starts at 1, 15 distinct nonzero states, then wraps
        rst_n = 1'b1;
        chk("a_start", int'(seq_x[0]), 1);
        seen_a[seq_a] = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            chk("a_seq", int'(seq_x[0]), int'(mdl[0]));
            chk("a_nz", int'(seq_x[0] != 8'h00), 1);
            if (i < 14) seen_a[seq_a] = 1'b1;
        end
        chk("a_wrap", int'(seq_x[0]), 1);
        chk("a_distinct", $countones(seen_a), 15);

        repeat (3) @(negedge clk);
        sload_x[0] = 1'b1;
        seed_x[0]  = 8'h00;
        @(negedge clk);
        chk("a_seed0", int'(seq_x[0]), 1);
        seed_x[0] = 8'h09;
        @(negedge clk);
        sload_x[0] = 1'b0;
        chk("a_seed9", int'(seq_x[0]), 9);

        run_req(0, 5, 1'b1, 8'h07);
        run_req(0, 9, 1'b1, 8'h00);
        run_req(0, 15, 1'b0, 8'h00);
        run_req(0, 1, 1'b0, 8'h00);
        run_req(0, 3, 1'b1, 8'h02);
        run_req(0, 12, 1'b0, 8'h00);
        run_req(0, 0, 1'b0, 8'h00);
        run_req(0, 6, 1'b0, 8'h00);
        run_req(0, 1, 1'b0, 8'h00);

        for (int n = 0; n < 2000; n++) begin
            run_req(1, 10, (n % 7) == 3, 8'($urandom));
        end
        chk("b_cover", int'(seen_b[9:0]), 'h3FF);

        for (int n = 0; n < 200; n++) begin
            run_req(2, 129, 1'b0, 8'h00);
        end

        // Reset dropped into the middle of a SAMPLE cycle
        req_x[0]   = 1'b1;
        bound_x[0] = 8'd9;
        @(negedge clk);
        req_x[0] = 1'b0;
        chk("mid_rdy", int'(rdy_x[0]), 0);
        chk("mid_vld", int'(vld_x[0]), 0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rdy", int'(rdy_x[0]), 1);
        chk("async_vld", int'(vld_x[0]), 0);
        chk("async_seq", int'(seq_x[0]), 1);
        @(negedge clk);
        rst_n = 1'b1;
        flag  = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (vld_x[0]) flag = 1'b1;
        end
        chk("no_vld_after_rst", int'(flag), 0);
        chk("rdy_after_rst", int'(rdy_x[0]), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
